// File: rtl/ps2_pkg.sv
// Shared types and frame helpers for the device-side PS/2 transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        BIT_HIGH,
        BIT_LOW,
        STOP_GAP
    } state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Odd parity: total number of ones over data+parity is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Line level of frame position idx: start, data LSB first, parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
        logic b;
        if (idx == 4'd0)
            b = START_BIT;
        else if (idx <= 4'd8)
            b = d[3'(idx - 4'd1)];
        else if (idx == 4'd9)
            b = odd_parity(d);
        else
            b = STOP_BIT;
        return b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO with count-based full/empty; a push and a pop in
// the same cycle are accepted even when full.
module ps2_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock and shifts out
// 11-bit frames on open-drain lines, backing off when the host inhibits.
// Optional macro PS2_DEVICE_TX_FIFO_EN puts a FIFO_DEPTH-entry FIFO in
// front of the shifter; without it a single byte is held.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int PS2_CLK_HZ  = 12500,
    parameter int IDLE_CYCLES = 2500,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_aborted,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int HALF = CLK_FREQ_HZ / (2 * PS2_CLK_HZ);
    localparam int CMAX = (HALF > IDLE_CYCLES) ? HALF : IDLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

    generate
        if (HALF < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
            $error("ps2_device_tx: HALF must be >= 4 and FIFO_DEPTH a power of 2");
        end
    endgenerate

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_n;
    logic [7:0]    shreg;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          load, done_n, abort_n;
    logic          ready_q;
    logic          have_byte;
    logic [7:0]    new_byte;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

`ifdef PS2_DEVICE_TX_FIFO_EN
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;

    ps2_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && tx_ready),
        .wdata (tx_data),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready  = ready_q && !fifo_full;
    assign have_byte = !fifo_empty;
    assign new_byte  = fifo_rdata;
    assign tx_busy   = !fifo_empty || (state != IDLE);
`else
    assign tx_ready  = ready_q;
    assign have_byte = tx_valid && ready_q;
    assign new_byte  = tx_data;
    assign tx_busy   = (state != IDLE);
`endif

    // Two-flop synchronisers; lines idle high so reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    // Next-state logic: bus-idle wait, half-period timing, inhibit detect.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        load    = 1'b0;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (have_byte) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                if (clk_s && dat_s) begin
                    if (cnt == IDLE_LAST) begin
                        cnt_n   = '0;
                        bit_n   = '0;
                        state_n = BIT_HIGH;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            BIT_HIGH: begin
                // First two cycles still see the synchroniser echo of our own low.
                if (cnt >= CW'(2) && !clk_s) begin
                    abort_n = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT_BUS;
                end else if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = BIT_LOW;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BIT_LOW: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_n = STOP_GAP;
                    end else begin
                        bit_n   = bit_idx + 4'd1;
                        state_n = BIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP_GAP: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register plus registered line drivers and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_aborted <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            if (load) shreg <= new_byte;
            ps2_clk_oe <= (state_n == BIT_LOW);
            ps2_dat_oe <= ((state_n == BIT_HIGH) || (state_n == BIT_LOW)) &&
                          !frame_bit(shreg, bit_n);
            tx_done    <= done_n;
            tx_aborted <= abort_n;
`ifdef PS2_DEVICE_TX_FIFO_EN
            ready_q    <= 1'b1;
`else
            ready_q    <= (state_n == IDLE);
`endif
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx with HALF=4, IDLE_CYCLES=8.
// A host model samples the data line on clock-line falling edges and
// compares each 11-bit frame against the expected-frame queue.
module tb_ps2_device_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_aborted;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;
    logic       clk_line, dat_line;

    assign clk_line = !(ps2_clk_oe || host_clk_low);
    assign dat_line = !(ps2_dat_oe || host_dat_low);

    ps2_device_tx #(
        .CLK_FREQ_HZ (100000),
        .PS2_CLK_HZ  (12500),
        .IDLE_CYCLES (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_aborted (tx_aborted),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    logic [10:0] exp_q[$];
    logic [10:0] acc = '0;
    int          nbits = 0;
    int          done_cnt = 0, abort_cnt = 0, rise_cnt = 0;
    longint      pcnt = 0, first_bit_edge = 0, done_edge = 0;

    function automatic void check(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Expected frame {stop, parity, data, start}; bit 0 goes out first.
    function automatic logic [10:0] fr(input logic par, input logic [7:0] d);
        return {1'b1, par, d, 1'b0};
    endfunction

    always @(posedge clk) pcnt++;
    always @(posedge ps2_clk_oe) rise_cnt++;

    // Host model: sample data on device-driven clock falling edges.
    always @(negedge clk_line) begin
        if (!host_clk_low && !reset) begin
            acc = {dat_line, acc[10:1]};
            nbits++;
            if (nbits == 1) first_bit_edge = pcnt;
            if (nbits == 11) begin
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", acc, 0);
                end else begin
                    check("frame", acc, exp_q.pop_front());
                end
                nbits = 0;
            end
        end
    end

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset || tx_aborted) nbits = 0;
        if (tx_aborted) abort_cnt++;
        if (tx_done) begin
            done_cnt++;
            done_edge = pcnt;
            check("bits_at_done", nbits, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int k = 0;
        while (!tx_ready && k < 3000) begin tick(); k++; end
        if (k >= 3000) check("ready_timeout", 0, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 3000) begin tick(); k++; end
        check("done_count", done_cnt, target);
    endtask

    task automatic wait_rises(input int target);
        int k = 0;
        while (rise_cnt < target && k < 3000) begin tick(); k++; end
        check("rise_count", rise_cnt, target);
        k = 0;
        while (ps2_clk_oe && k < 20) begin tick(); k++; end
    endtask

    initial begin
        int base, k, ok, dcnt, acnt;
        repeat (3) tick();
        check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_aborted, tx_ready}, 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", tx_ready, 1);

        // 0x1C: three ones -> parity 0; 22*HALF from first clock low to done.
        exp_q.push_back(fr(1'b0, 8'h1C));
        send(8'h1C);
        wait_done(1);
        check("frame_time", done_edge - first_bit_edge, 88);
        check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);

        exp_q.push_back(fr(1'b1, 8'h00));
        send(8'h00);
        wait_done(2);
        exp_q.push_back(fr(1'b1, 8'hFF));
        send(8'hFF);
        wait_done(3);

        // Host inhibit during bit 4 of 0xF0, then full resend.
        exp_q.push_back(fr(1'b1, 8'hF0));
        base = rise_cnt;
        acnt = abort_cnt;
        send(8'hF0);
        wait_rises(base + 4);
        host_clk_low = 1'b1;
        ok = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!ps2_clk_oe && !ps2_dat_oe) ok = 1;
        end
        check("abort_release", ok, 1);
        repeat (4) tick();
        host_clk_low = 1'b0;
        check("abort_pulses", abort_cnt - acnt, 1);
        wait_done(4);
        check("abort_pulses_after", abort_cnt - acnt, 1);

        // Host holds data low: no clocking until released.
        host_dat_low = 1'b1;
        repeat (4) tick();
        exp_q.push_back(fr(1'b0, 8'h75));
        base = rise_cnt;
        send(8'h75);
        repeat (60) tick();
        check("rts_no_clock", rise_cnt - base, 0);
        check("rts_busy", tx_busy, 1);
        host_dat_low = 1'b0;
        k = 0;
        while (!ps2_dat_oe && k < 40) begin tick(); k++; end
        check("rts_start_delay", k, 10);
        wait_done(5);

        // Reset during bit 6: byte dropped, no pulses.
        base = rise_cnt;
        dcnt = done_cnt;
        acnt = abort_cnt;
        send(8'hAA);
        wait_rises(base + 6);
        reset = 1'b1;
        tick();
        check("reset_mid_frame", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 0);
        reset = 1'b0;
        repeat (30) tick();
        check("reset_no_pulses", (done_cnt - dcnt) + (abort_cnt - acnt), 0);
        exp_q.push_back(fr(1'b1, 8'h5A));
        send(8'h5A);
        wait_done(dcnt + 1);

`ifdef PS2_DEVICE_TX_FIFO_EN
        begin
            logic [7:0] seq [5];
            logic       par [5];
            seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
            par = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            dcnt = done_cnt;
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(fr(par[i], seq[i]));
                tx_data  = seq[i];
                tx_valid = 1'b1;
                k = 0;
                while (!tx_ready && k < 3000) begin tick(); k++; end
                tick();
            end
            tx_valid = 1'b0;
            check("fifo_full_ready", tx_ready, 0);
            k = 0;
            while (!tx_ready && k < 3000) begin tick(); k++; end
            check("fifo_ready_after_pop", done_cnt - dcnt, 1);
            wait_done(dcnt + 5);
            repeat (20) tick();
            check("fifo_done_total", done_cnt - dcnt, 5);
        end
`endif

        repeat (10) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
